// File: rtl/uart_rx.sv
// UART receiver: 2-FF synchronised line, oversampled mid-bit sampling,
// LSB-first deserialisation with stop-bit framing check.
//
// state | meaning
// IDLE  | line idle, waiting for a low on rx_s
// START | confirming the start bit at its midpoint
// DATA  | sampling WORD_LENGHT data bits
// STOP  | sampling the stop bit
// BREAK | framing error seen, waiting for the line to return high
module uart_rx #(
  parameter int WORD_LENGHT = 8,
  parameter int FREQUENCY   = 50000000,
  parameter int BAUDRATE    = 9600,
  parameter int OVERSAMPLE  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   Rx_in,
  output logic [WORD_LENGHT-1:0] Rx_out,
  output logic                   new_Rx,
  output logic                   frame_error,
  output logic                   busy
);

  localparam int DIV   = FREQUENCY / (BAUDRATE * OVERSAMPLE);
  // DIV == 1 would give a zero-width counter; keep at least one bit.
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int S_W   = $clog2(OVERSAMPLE);
  localparam int B_W   = $clog2(WORD_LENGHT + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [S_W-1:0]   S_MID    = S_W'(OVERSAMPLE / 2 - 1);
  localparam logic [S_W-1:0]   S_LAST   = S_W'(OVERSAMPLE - 1);
  localparam logic [B_W-1:0]   B_LAST   = B_W'(WORD_LENGHT - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BREAK = 3'd4;

  logic                   rx_meta;
  logic                   rx_s;
  logic [2:0]             state;
  logic [DIV_W-1:0]       div_cnt;
  logic                   tick;
  logic [S_W-1:0]         s_cnt;
  logic [B_W-1:0]         bit_cnt;
  logic [WORD_LENGHT-1:0] shift;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= Rx_in;
      rx_s    <= rx_meta;
    end
  end

  // Held at zero while idle so the tick phase is aligned to the start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      div_cnt <= '0;
    else if (state == IDLE || div_cnt == DIV_LAST)
      div_cnt <= '0;
    else
      div_cnt <= div_cnt + 1'b1;
  end

  assign tick = (div_cnt == DIV_LAST);
  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      s_cnt       <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      Rx_out      <= '0;
      new_Rx      <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      new_Rx <= 1'b0;
      case (state)
        IDLE: begin
          s_cnt <= '0;
          if (!rx_s) state <= START;
        end
        START: begin
          if (tick) begin
            if (s_cnt == S_MID) begin
              s_cnt   <= '0;
              bit_cnt <= '0;
              if (rx_s) begin
                state <= IDLE;
              end else begin
                state       <= DATA;
                frame_error <= 1'b0;
              end
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (s_cnt == S_LAST) begin
              s_cnt   <= '0;
              shift   <= {rx_s, shift[WORD_LENGHT-1:1]};
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == B_LAST) state <= STOP;
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (s_cnt == S_LAST) begin
              s_cnt <= '0;
              // Leaving at mid stop bit leaves room for a zero-gap next start bit.
              if (rx_s) begin
                Rx_out <= shift;
                new_Rx <= 1'b1;
                state  <= IDLE;
              end else begin
                frame_error <= 1'b1;
                state       <= BREAK;
              end
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
        end
        BREAK: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
